hpu_lsu_stbuf: RTL and testbench

HPU_LSU_STBUF -- requirements
Module: hpu_lsu_stbuf

---
 rtl/hpu_lsu_stbuf.sv | 188 ++++++++++++++++++
 tb/tb_hpu_lsu_stbuf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_lsu_stbuf.sv
// +----------------------------------------------------------------------------+
// | hpu_lsu_stbuf: speculative store buffer with commit, flush, drain, fwd.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hpu_lsu_stbuf #(
  parameter int SB_DEPTH = 4,
  parameter int SB_INDEX = 2,
  parameter int PC_WTH   = 32,
  parameter int DATA_WTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_en_i,
  input  logic                exu_wb__sb_we_i,
  input  logic [PC_WTH-1:0]   exu_wb__mem_addr_i,
  input  logic [DATA_WTH-1:0] exu_wb__st_rs2_data_i,
  input  logic                cmt_sb__cmt_en_i,
  output logic                sb_exu__full_o,
  output logic                sb_mem__wr_en_o,
  output logic [PC_WTH-1:0]   sb_mem__waddr_o,
  output logic [DATA_WTH-1:0] sb_mem__wdata_o,
  input  logic                mem_sb__wr_rdy_i,
  input  logic [PC_WTH-1:0]   ld_sb__raddr_i,
  output logic                sb_ld__fwd_hit_o,
  output logic [DATA_WTH-1:0] sb_ld__fwd_data_o,
  output logic                sb__empty_o
);

  localparam int PTR_W = SB_INDEX + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drain_st_e;

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    cmt_q, cmt_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic                valid_q     [SB_DEPTH];
  logic                valid_d     [SB_DEPTH];
  logic                committed_q [SB_DEPTH];
  logic                committed_d [SB_DEPTH];
  logic [PC_WTH-1:0]   addr_q      [SB_DEPTH];
  logic [PC_WTH-1:0]   addr_d      [SB_DEPTH];
  logic [DATA_WTH-1:0] data_q      [SB_DEPTH];
  logic [DATA_WTH-1:0] data_d      [SB_DEPTH];

  drain_st_e           state_q;
  logic                wr_en_q;
  logic [PC_WTH-1:0]   waddr_q;
  logic [DATA_WTH-1:0] wdata_q;

  logic [SB_INDEX-1:0] w_head_idx;
  logic [SB_INDEX-1:0] w_cmt_idx;
  logic [SB_INDEX-1:0] w_tail_idx;
  logic [PTR_W-1:0]    w_count;
  logic                w_full;
  logic                w_alloc;
  logic                w_commit;
  logic                w_drain_acc;

  assign w_head_idx  = head_q[SB_INDEX-1:0];
  assign w_cmt_idx   = cmt_q[SB_INDEX-1:0];
  assign w_tail_idx  = tail_q[SB_INDEX-1:0];
  assign w_count     = tail_q - head_q;
  assign w_full      = (w_count == PTR_W'(SB_DEPTH));
  assign w_alloc     = exu_wb__sb_we_i && !w_full && !flush_en_i;
  assign w_commit    = cmt_sb__cmt_en_i && (cmt_q != tail_q);
  assign w_drain_acc = (state_q == ST_REQ) && mem_sb__wr_rdy_i;

  assign sb_exu__full_o  = w_full;
  assign sb__empty_o     = (tail_q == head_q);
  assign sb_mem__wr_en_o = wr_en_q;
  assign sb_mem__waddr_o = waddr_q;
  assign sb_mem__wdata_o = wdata_q;

  // Commit is applied first so a same-cycle flush keeps the newly committed entry.
  always_comb begin
    head_d      = head_q;
    cmt_d       = cmt_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    committed_d = committed_q;
    addr_d      = addr_q;
    data_d      = data_q;

    if (w_commit) begin
      committed_d[w_cmt_idx] = 1'b1;
      cmt_d                  = cmt_q + PTR_W'(1);
    end

    if (flush_en_i) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (!committed_d[i]) valid_d[i] = 1'b0;
      end
      tail_d = cmt_d;
    end else if (w_alloc) begin
      valid_d[w_tail_idx]     = 1'b1;
      committed_d[w_tail_idx] = 1'b0;
      addr_d[w_tail_idx]      = exu_wb__mem_addr_i;
      data_d[w_tail_idx]      = exu_wb__st_rs2_data_i;
      tail_d                  = tail_q + PTR_W'(1);
    end

    if (w_drain_acc) begin
      valid_d[w_head_idx]     = 1'b0;
      committed_d[w_head_idx] = 1'b0;
      head_d                  = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        valid_q[i]     <= 1'b0;
        committed_q[i] <= 1'b0;
        addr_q[i]      <= '0;
        data_q[i]      <= '0;
      end
    end else begin
      head_q      <= head_d;
      cmt_q       <= cmt_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      committed_q <= committed_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  // Drain FSM: outputs are registered, so the request holds stable until accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_q[w_head_idx] && committed_q[w_head_idx]) begin
            state_q <= ST_REQ;
            wr_en_q <= 1'b1;
            waddr_q <= addr_q[w_head_idx];
            wdata_q <= data_q[w_head_idx];
          end
        end
        ST_REQ: begin
          if (mem_sb__wr_rdy_i) begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_en_q <= 1'b0;
          waddr_q <= '0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  logic [SB_INDEX-1:0] w_scan_idx;
  always_comb begin
    sb_ld__fwd_hit_o  = 1'b0;
    sb_ld__fwd_data_o = '0;
    w_scan_idx        = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_scan_idx = w_head_idx + SB_INDEX'(i);
      if (valid_q[w_scan_idx] && (addr_q[w_scan_idx] == ld_sb__raddr_i)) begin
        sb_ld__fwd_hit_o  = 1'b1;
        sb_ld__fwd_data_o = data_q[w_scan_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hpu_lsu_stbuf.sv
// +----------------------------------------------------------------------------+
// | tb_hpu_lsu_stbuf: directed and random stimulus against a queue model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hpu_lsu_stbuf;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_en_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        cmt_i = 1'b0;
  logic        rdy_i = 1'b0;
  logic [31:0] raddr_i = '0;
  logic        full_o, wr_en_o, hit_o, empty_o;
  logic [31:0] waddr_o, wdata_o, fwd_o;

  hpu_lsu_stbuf #(.SB_DEPTH(DEPTH), .SB_INDEX(2), .PC_WTH(32), .DATA_WTH(32)) u_dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .flush_en_i            (flush_en_i),
    .exu_wb__sb_we_i       (we_i),
    .exu_wb__mem_addr_i    (addr_i),
    .exu_wb__st_rs2_data_i (data_i),
    .cmt_sb__cmt_en_i      (cmt_i),
    .sb_exu__full_o        (full_o),
    .sb_mem__wr_en_o       (wr_en_o),
    .sb_mem__waddr_o       (waddr_o),
    .sb_mem__wdata_o       (wdata_o),
    .mem_sb__wr_rdy_i      (rdy_i),
    .ld_sb__raddr_i        (raddr_i),
    .sb_ld__fwd_hit_o      (hit_o),
    .sb_ld__fwd_data_o     (fwd_o),
    .sb__empty_o           (empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  // Model: queue of stores oldest-first; committed stores are a prefix of m_ncmt.
  ent_t m_q[$];
  int   m_ncmt = 0;
  bit   m_busy = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs();
    logic        e_hit;
    logic [31:0] e_fwd;
    e_hit = 1'b0;
    e_fwd = '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (!e_hit && m_q[i].a == raddr_i) begin
        e_hit = 1'b1;
        e_fwd = m_q[i].d;
      end
    end
    chk("full",     64'(full_o),  64'(m_q.size() == DEPTH));
    chk("empty",    64'(empty_o), 64'(m_q.size() == 0));
    chk("wr_en",    64'(wr_en_o), 64'(m_busy));
    chk("waddr",    64'(waddr_o), 64'(m_busy ? m_q[0].a : 32'h0));
    chk("wdata",    64'(wdata_o), 64'(m_busy ? m_q[0].d : 32'h0));
    chk("fwd_hit",  64'(hit_o),   64'(e_hit));
    chk("fwd_data", 64'(fwd_o),   64'(e_fwd));
  endtask

  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit c, input bit f, input bit r, input logic [31:0] ra);
    bit full_pre, acc, start;
    @(negedge clk_i);
    we_i = we; addr_i = a; data_i = d; cmt_i = c; flush_en_i = f; rdy_i = r; raddr_i = ra;
    #1;
    check_outs();
    @(posedge clk_i);
    full_pre = (m_q.size() == DEPTH);
    acc      = m_busy && r;
    start    = !m_busy && (m_ncmt > 0);
    if (c && m_ncmt < m_q.size()) m_ncmt++;
    if (f) begin
      while (m_q.size() > m_ncmt) void'(m_q.pop_back());
    end else if (we && !full_pre) begin
      m_q.push_back('{a: a, d: d});
    end
    if (acc) begin
      void'(m_q.pop_front());
      m_ncmt--;
      m_busy = 1'b0;
    end else if (start) begin
      m_busy = 1'b1;
    end
  endtask

  task automatic idle(input bit r);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, r, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit r);
    step(1'b1, a, d, 1'b0, 1'b0, r, 32'h0);
  endtask

  task automatic commit(input bit r);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, r, 32'h0);
  endtask

  task automatic check_reset_outs();
    chk("rst_full",  64'(full_o),  64'h0);
    chk("rst_empty", 64'(empty_o), 64'h1);
    chk("rst_wr_en", 64'(wr_en_o), 64'h0);
    chk("rst_waddr", 64'(waddr_o), 64'h0);
    chk("rst_wdata", 64'(wdata_o), 64'h0);
    chk("rst_hit",   64'(hit_o),   64'h0);
    chk("rst_fwd",   64'(fwd_o),   64'h0);
  endtask

  task automatic async_reset();
    @(negedge clk_i);
    we_i = 1'b0; cmt_i = 1'b0; flush_en_i = 1'b0; rdy_i = 1'b0;
    #2 rst_i = 1'b0;
    #1 check_reset_outs();
    m_q.delete();
    m_ncmt = 0;
    m_busy = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    int wait_cyc;
    #1 check_reset_outs();
    @(negedge clk_i);
    rst_i = 1'b1;

    // Single store: allocate, commit, drain
    store(32'h8000_0010, 32'hAAAA_5555, 1'b1);
    commit(1'b1);
    chk("lat_pre", 64'(wr_en_o), 64'h0);
    idle(1'b1);
    #1 chk("lat_req", 64'(wr_en_o), 64'h1);
    chk("lat_addr", 64'(waddr_o), 64'h8000_0010);
    repeat (3) idle(1'b1);
    #1 chk("drained_empty", 64'(empty_o), 64'h1);

    // Fill without commit, overflow store dropped, flush empties
    for (int i = 0; i < 5; i++) store(32'h100 + 32'(i * 4), 32'(i), 1'b1);
    #1 chk("full4", 64'(full_o), 64'h1);
    step(1'b1, 32'h200, 32'h9, 1'b0, 1'b1, 1'b1, 32'h0);
    #1 chk("flush_empty", 64'(empty_o), 64'h1);
    chk("flush_full", 64'(full_o), 64'h0);
    repeat (3) idle(1'b1);

    // Youngest match forwards
    store(32'h0210_0000, 32'h1, 1'b1);
    store(32'h0210_0000, 32'h2, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0210_0000);
    #1 chk("fwd_young", 64'(fwd_o), 64'h2);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);

    // Back-pressure hold then accept
    store(32'h0000_0040, 32'hCAFE_0001, 1'b0);
    commit(1'b0);
    repeat (6) idle(1'b0);
    repeat (3) idle(1'b1);

    // Flush with same-cycle commit keeps the third store
    store(32'h50, 32'hA, 1'b0);
    store(32'h54, 32'hB, 1'b0);
    store(32'h58, 32'hC, 1'b0);
    commit(1'b0);
    commit(1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h58);
    wait_cyc = 0;
    while (m_q.size() != 0 && wait_cyc < 20) begin
      idle(1'b1);
      wait_cyc++;
    end
    chk("drain3_timeout", 64'(wait_cyc < 20), 64'h1);

    // Repeated fill/drain wraps pointers
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) store(32'h1000 + 32'(i * 4), 32'(k * 16 + i), 1'b1);
      for (int i = 0; i < DEPTH; i++) commit(1'b1);
      repeat (10) idle(1'b1);
    end

    // Reset while a drain request is outstanding
    store(32'h0000_0080, 32'h1234_5678, 1'b0);
    commit(1'b0);
    repeat (3) idle(1'b0);
    async_reset();
    repeat (3) idle(1'b1);

    // Randomized traffic on a small address pool so forwarding hits
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 1) == 1,
           32'h3000 + 32'($urandom_range(0, 3) * 4),
           $urandom,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0,
           32'h3000 + 32'($urandom_range(0, 4) * 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
